alu4_sequencer: RTL and testbench

ALU4_SEQUENCER -- requirements
Module: alu4_sequencer

---
 rtl/alu4_sequencer.sv | 133 +++++++++++++
 tb/tb_alu4_sequencer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/alu4_sequencer.sv
// rtl/alu4_sequencer.sv - command sequencer driving an external 4-bit ALU
// Holds r0..r3 and {C,R,V,Z}; issues reg-reg/reg-imm ops, loads and reads.
module alu4_sequencer #(
  parameter int unsigned ALU_WAIT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [15:0] cmd,
  output logic [3:0]  alu_op,
  output logic [3:0]  alu_a,
  output logic [3:0]  alu_b,
  output logic        alu_ci,
  output logic        alu_rci,
  input  logic [3:0]  alu_y,
  input  logic        alu_co,
  input  logic        alu_rco,
  input  logic        alu_ov,
  input  logic        alu_z,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [3:0]  res_data,
  output logic [3:0]  res_flags
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  localparam logic [2:0] WAIT_LOAD = 3'(ALU_WAIT - 1);

  state_t     state, state_nxt;
  logic [3:0] regs [4];
  logic [3:0] flags;
  logic [2:0] cnt;
  logic [3:0] op_q, imm_q;
  logic [1:0] rd_q, ra_q, rb_q;
  logic       imm_sel_q;

  logic [1:0] cmd_mode;
  logic [3:0] cmd_op, cmd_imm;
  logic [1:0] cmd_rd, cmd_ra, cmd_rb;

  assign cmd_mode  = cmd[15:14];
  assign cmd_op    = cmd[13:10];
  assign cmd_rd    = cmd[9:8];
  assign cmd_ra    = cmd[7:6];
  assign cmd_rb    = cmd[5:4];
  assign cmd_imm   = cmd[3:0];
  assign res_flags = flags;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // ALU drive is purely a function of state so reset clears it without a clock
  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    res_valid = 1'b0;
    alu_op    = 4'h0;
    alu_a     = 4'h0;
    alu_b     = 4'h0;
    alu_ci    = 1'b0;
    alu_rci   = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = rst_n;
        if (cmd_valid) state_nxt = cmd_mode[1] ? RESP : ISSUE;
      end
      ISSUE: begin
        alu_op  = op_q;
        alu_a   = regs[ra_q];
        alu_b   = imm_sel_q ? imm_q : regs[rb_q];
        alu_ci  = flags[3];
        alu_rci = flags[2];
        if (cnt == 3'd0) state_nxt = RESP;
      end
      RESP: begin
        res_valid = 1'b1;
        if (res_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) regs[i] <= 4'h0;
      flags     <= 4'h0;
      cnt       <= 3'd0;
      res_data  <= 4'h0;
      op_q      <= 4'h0;
      imm_q     <= 4'h0;
      rd_q      <= 2'd0;
      ra_q      <= 2'd0;
      rb_q      <= 2'd0;
      imm_sel_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            op_q      <= cmd_op;
            imm_q     <= cmd_imm;
            rd_q      <= cmd_rd;
            ra_q      <= cmd_ra;
            rb_q      <= cmd_rb;
            imm_sel_q <= cmd_mode[0];
            cnt       <= WAIT_LOAD;
            if (cmd_mode == 2'b10) begin
              regs[cmd_rd] <= cmd_imm;
              res_data     <= cmd_imm;
            end else if (cmd_mode == 2'b11) begin
              res_data <= regs[cmd_rd];
            end
          end
        end
        ISSUE: begin
          // destination is written only at capture, so rd may alias ra/rb
          if (cnt == 3'd0) begin
            regs[rd_q] <= alu_y;
            flags      <= {alu_co, alu_rco, alu_ov, alu_z};
            res_data   <= alu_y;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu4_sequencer.sv
// tb/tb_alu4_sequencer.sv - scoreboard bench for alu4_sequencer
// Two instances (ALU_WAIT=1 and 3) share stimulus; sel picks the active one.
module tb_alu4_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic [15:0] cmd;
  logic        res_ready;
  int          sel;

  logic        cmd_valid_w [2];
  logic        cmd_ready_w [2];
  logic [3:0]  alu_op_w [2], alu_a_w [2], alu_b_w [2];
  logic        alu_ci_w [2], alu_rci_w [2];
  logic [3:0]  alu_y_w [2];
  logic        alu_co_w [2], alu_rco_w [2], alu_ov_w [2], alu_z_w [2];
  logic        res_valid_w [2];
  logic [3:0]  res_data_w [2], res_flags_w [2];

  int tests = 0;
  int fails = 0;
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  // op0 add-with-carry, op6 add, op5 rotate-left through R, else xor
  function automatic logic [7:0] alu_model(input logic [3:0] op, a, b, input logic ci, rci);
    logic [4:0] s;
    logic [3:0] y;
    logic co, rco, ov;
    s = 5'(a) + 5'(b) + ((op == 4'h0) ? 5'(ci) : 5'd0);
    y = a ^ b; co = 1'b0; rco = 1'b0; ov = 1'b0;
    if (op == 4'h0 || op == 4'h6) begin
      y = s[3:0]; co = s[4]; ov = (a[3] == b[3]) && (y[3] != a[3]);
    end else if (op == 4'h5) begin
      y = {a[2:0], rci}; rco = a[3];
    end
    return {y, co, rco, ov, (y == 4'h0)};
  endfunction

  for (genvar i = 0; i < 2; i++) begin : g_dut
    assign cmd_valid_w[i] = cmd_valid && (sel == i);
    assign {alu_y_w[i], alu_co_w[i], alu_rco_w[i], alu_ov_w[i], alu_z_w[i]} =
      alu_model(alu_op_w[i], alu_a_w[i], alu_b_w[i], alu_ci_w[i], alu_rci_w[i]);
    alu4_sequencer #(.ALU_WAIT(i == 0 ? 1 : 3)) u_dut (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid_w[i]), .cmd_ready(cmd_ready_w[i]),
      .cmd(cmd), .alu_op(alu_op_w[i]), .alu_a(alu_a_w[i]), .alu_b(alu_b_w[i]),
      .alu_ci(alu_ci_w[i]), .alu_rci(alu_rci_w[i]), .alu_y(alu_y_w[i]),
      .alu_co(alu_co_w[i]), .alu_rco(alu_rco_w[i]), .alu_ov(alu_ov_w[i]), .alu_z(alu_z_w[i]),
      .res_valid(res_valid_w[i]), .res_ready(res_ready),
      .res_data(res_data_w[i]), .res_flags(res_flags_w[i])
    );
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_alu_idle(input string name);
    chk(name, {alu_op_w[sel], alu_a_w[sel], alu_b_w[sel], 2'b00, alu_ci_w[sel], alu_rci_w[sel]}, 16'h0);
  endtask

  // Monitor: pops one expectation per result handshake
  always @(negedge clk) begin
    if (rst_n && res_valid_w[sel] && res_ready) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_result: got data 0x%0h flags 0x%0h with empty queue",
                 res_data_w[sel], res_flags_w[sel]);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if ({res_data_w[sel], res_flags_w[sel]} !== e) begin
          fails++;
          $display("FAIL result: got data 0x%0h flags 0x%0h expected data 0x%0h flags 0x%0h",
                   res_data_w[sel], res_flags_w[sel], e[7:4], e[3:0]);
        end
      end
    end
  end

  // Called just after a posedge; returns just after the result handshake edge
  task automatic run_cmd(input logic [15:0] c, input int lat, input logic [3:0] ed, ef,
                         input bit chk_ops, input logic [3:0] ea, eb, input logic eci);
    int n;
    exp_q.push_back({ed, ef});
    cmd = c;
    cmd_valid = 1'b1;
    @(negedge clk);
    chk("cmd_ready", 16'(cmd_ready_w[sel]), 16'h1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd = 16'h0;
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      n++;
      if (res_valid_w[sel]) break;
      if (chk_ops) begin
        chk("issue_a", 16'(alu_a_w[sel]), 16'(ea));
        chk("issue_b", 16'(alu_b_w[sel]), 16'(eb));
        chk("issue_ci_rci", {14'h0, alu_ci_w[sel], alu_rci_w[sel]}, {14'h0, eci, 1'b0});
      end
    end
    chk("latency", 16'(n), 16'(lat));
    chk_alu_idle("resp_alu_zero");
    @(posedge clk);
    #1;
  endtask

  initial begin
    sel = 0; rst_n = 1'b0; cmd_valid = 1'b0; cmd = 16'h0; res_ready = 1'b1;
    #3;
    chk("rst_cmd_ready", 16'(cmd_ready_w[0]), 16'h0);
    chk("rst_res", {res_valid_w[0], 7'h0, res_data_w[0], res_flags_w[0]}, 16'h0);
    chk_alu_idle("rst_alu_zero");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rel_cmd_ready", 16'(cmd_ready_w[0]), 16'h1);
    @(posedge clk);
    #1;

    run_cmd(16'h8105, 1, 4'h5, 4'h0, 0, 4'h0, 4'h0, 1'b0);
    run_cmd(16'hC100, 1, 4'h5, 4'h0, 0, 4'h0, 4'h0, 1'b0);
    run_cmd(16'h8203, 1, 4'h3, 4'h0, 0, 4'h0, 4'h0, 1'b0);
    run_cmd(16'h1B60, 2, 4'h8, 4'b0010, 1, 4'h5, 4'h3, 1'b0);
    run_cmd(16'hC300, 1, 4'h8, 4'b0010, 0, 4'h0, 4'h0, 1'b0);

    // stalled response with a competing command pulsed meanwhile
    res_ready = 1'b0;
    exp_q.push_back({4'h5, 4'b0010});
    cmd = 16'hC100;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd = 16'h810A;
    repeat (4) begin
      @(negedge clk);
      chk("stall_hold", {3'h0, res_valid_w[0], 3'h0, cmd_ready_w[0], 4'h0, res_data_w[0]}, 16'h1005);
      @(posedge clk);
      #1 cmd_valid = ~cmd_valid;
    end
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    run_cmd(16'hC100, 1, 4'h5, 4'b0010, 0, 4'h0, 4'h0, 1'b0);

    run_cmd(16'h8107, 1, 4'h7, 4'b0010, 0, 4'h0, 4'h0, 1'b0);
    run_cmd(16'h5942, 2, 4'h9, 4'b0010, 1, 4'h7, 4'h2, 1'b0);
    run_cmd(16'hC100, 1, 4'h9, 4'b0010, 0, 4'h0, 4'h0, 1'b0);
    run_cmd(16'h5847, 2, 4'h0, 4'b1001, 1, 4'h9, 4'h7, 1'b0);

    sel = 1;
    run_cmd(16'h8009, 1, 4'h9, 4'h0, 0, 4'h0, 4'h0, 1'b0);
    run_cmd(16'h5807, 4, 4'h0, 4'b1001, 1, 4'h9, 4'h7, 1'b0);
    run_cmd(16'h410F, 4, 4'h0, 4'b1001, 1, 4'h0, 4'hF, 1'b1);

    // reset in the middle of ISSUE: no write, no result, ALU drive cleared at once
    cmd = 16'h5A09;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    chk("abort_pre_b", 16'(alu_b_w[1]), 16'h9);
    #1 rst_n = 1'b0;
    #1;
    chk_alu_idle("abort_alu_zero");
    chk("abort_res", {res_valid_w[1], 3'h0, cmd_ready_w[1], 3'h0, res_flags_w[1], res_data_w[1]}, 16'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_cmd(16'hC200, 1, 4'h0, 4'h0, 0, 4'h0, 4'h0, 1'b0);

    repeat (2) @(posedge clk);
    chk("queue_empty", 16'(exp_q.size()), 16'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
